// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared register width, zero register and stall-cause bit positions
package hazard_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam int ZERO_REG = 0;
  localparam int CAUSE_LOAD = 0;
  localparam int CAUSE_MD_DEP = 1;
  localparam int CAUSE_MD_FULL = 2;
  localparam int CAUSE_W = 3;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D/DX hazard inputs and stall/counter outputs of the scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_W = hazard_scoreboard_pkg::REG_W,
  parameter int MD_SLOTS = 2,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] rs_d, rt_d, rd_d, rd_dx;
  logic isSw_d, isMD_d, isLw_dx, isMul_dx, isDiv_dx, MD_resultRDY_x;
  logic stall, load_stall, md_dep_stall, md_full_stall;
  logic [MD_SLOTS:0] md_pending;
  logic [CNT_W-1:0] stall_cnt, md_stall_cnt;
  modport master (
    output rs_d, rt_d, rd_d, rd_dx, isSw_d, isMD_d, isLw_dx, isMul_dx, isDiv_dx, MD_resultRDY_x,
    input stall, load_stall, md_dep_stall, md_full_stall, md_pending, stall_cnt, md_stall_cnt
  );
  modport slave (
    input rs_d, rt_d, rd_d, rd_dx, isSw_d, isMD_d, isLw_dx, isMul_dx, isDiv_dx, MD_resultRDY_x,
    output stall, load_stall, md_dep_stall, md_full_stall, md_pending, stall_cnt, md_stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_dest_fifo.sv
// hazard_dest_fifo: in-order FIFO of pending multdiv destinations with parallel 3-address hit compare
module hazard_dest_fifo #(
  parameter int REG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [REG_W-1:0] din,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  input  logic [REG_W-1:0] c,
  output logic             hit,
  output logic [DEPTH:0]   count
);
  import hazard_scoreboard_pkg::*;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = DEPTH + 1;
  logic [REG_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wp, rp;
  logic pop_ok;
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  function automatic logic match(input logic [REG_W-1:0] x, y);
    return x == y && x != REG_W'(ZERO_REG);
  endfunction
  assign pop_ok = pop && count != '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      vld <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (pop_ok) begin
        vld[rp] <= 1'b0;
        rp <= adv(rp);
      end
      if (push) begin
        vld[wp] <= 1'b1;
        wp <= adv(wp);
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  always_ff @(posedge clock)
    if (push) mem[wp] <= din;
  // An entry retiring this cycle still hits: its result is not forwardable yet
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (vld[i] && (match(mem[i], a) || match(mem[i], b) || match(mem[i], c)));
  end
  a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(push && !pop_ok && count == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(pop && count == '0));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and multdiv destination scoreboard driving the pipeline stall
module hazard_scoreboard #(
  parameter int REG_W = hazard_scoreboard_pkg::REG_W,
  parameter int MD_SLOTS = 2,
  parameter int LOAD_LAT = 1,
  parameter bit SW_BYPASS = 1'b1,
  parameter int CNT_W = 32
) (
  input logic clock,
  input logic reset,
  hazard_scoreboard_if.slave bus
);
  import hazard_scoreboard_pkg::*;
  localparam int CW = MD_SLOTS + 1;
  logic push, pop_ok, dep_fifo, dep_issue, load_stall;
  logic [MD_SLOTS:0] count, count_nxt;
  logic [CAUSE_W-1:0] cause;
  logic [LOAD_LAT-1:0][REG_W-1:0] ld;
  logic [REG_W-1:0] ld0;
  logic [CNT_W-1:0] stall_cnt, md_stall_cnt;
  function automatic logic match(input logic [REG_W-1:0] x, y);
    return x == y && x != REG_W'(ZERO_REG);
  endfunction
  assign push = bus.isMul_dx | bus.isDiv_dx;
  assign pop_ok = bus.MD_resultRDY_x && count != '0;
  assign ld0 = bus.isLw_dx ? bus.rd_dx : '0;
  // ld[0] is the live DX load; older stages cover loads still short of LOAD_LAT bubbles
  generate
    if (LOAD_LAT == 1) begin : g_comb
      assign ld = ld0;
    end else begin : g_chain
      logic [LOAD_LAT-2:0][REG_W-1:0] ld_q;
      assign ld = {ld_q, ld0};
      always_ff @(posedge clock or negedge reset)
        if (!reset) ld_q <= '0;
        else ld_q <= ld[LOAD_LAT-2:0];
    end
  endgenerate
  always_comb begin
    load_stall = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++)
      load_stall = load_stall | match(ld[k], bus.rs_d) | match(ld[k], bus.rt_d)
                 | (bus.isSw_d && !SW_BYPASS && match(ld[k], bus.rd_d));
  end
  hazard_dest_fifo #(.REG_W(REG_W), .DEPTH(MD_SLOTS)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(bus.MD_resultRDY_x),
    .din(bus.rd_dx),
    .a(bus.rs_d),
    .b(bus.rt_d),
    .c(bus.rd_d),
    .hit(dep_fifo),
    .count(count)
  );
  assign dep_issue = push && (match(bus.rd_dx, bus.rs_d) || match(bus.rd_dx, bus.rt_d) || match(bus.rd_dx, bus.rd_d));
  assign count_nxt = count + CW'(push) - CW'(pop_ok);
  assign cause[CAUSE_LOAD] = load_stall;
  assign cause[CAUSE_MD_DEP] = dep_fifo | dep_issue;
  assign cause[CAUSE_MD_FULL] = bus.isMD_d && count_nxt == CW'(MD_SLOTS);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (|cause && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((cause[CAUSE_MD_DEP] | cause[CAUSE_MD_FULL]) && !(&md_stall_cnt)) md_stall_cnt <= md_stall_cnt + CNT_W'(1);
    end
  assign bus.stall = |cause;
  assign bus.load_stall = cause[CAUSE_LOAD];
  assign bus.md_dep_stall = cause[CAUSE_MD_DEP];
  assign bus.md_full_stall = cause[CAUSE_MD_FULL];
  assign bus.md_pending = count;
  assign bus.stall_cnt = stall_cnt;
  assign bus.md_stall_cnt = md_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors on two configurations, checked against a queue-based model
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] s_rs = '0, s_rt = '0, s_rd = '0, s_rddx = '0;
  logic s_sw = 1'b0, s_md = 1'b0, s_lw = 1'b0, s_mul = 1'b0, s_div = 1'b0, s_rdy = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [4:0] mdq[$];
  logic [4:0] prev [2] = '{default: '0};
  longint ca_s = 0, ca_m = 0, cb_s = 0, cb_m = 0;
  localparam longint MAX_A = 64'hFFFF_FFFF;
  localparam longint MAX_B = 15;

  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_W(5), .MD_SLOTS(2), .CNT_W(32)) ia ();
  hazard_scoreboard_if #(.REG_W(5), .MD_SLOTS(2), .CNT_W(4)) ib ();

  assign {ia.rs_d, ia.rt_d, ia.rd_d, ia.rd_dx} = {s_rs, s_rt, s_rd, s_rddx};
  assign {ia.isSw_d, ia.isMD_d, ia.isLw_dx, ia.isMul_dx, ia.isDiv_dx, ia.MD_resultRDY_x} = {s_sw, s_md, s_lw, s_mul, s_div, s_rdy};
  assign {ib.rs_d, ib.rt_d, ib.rd_d, ib.rd_dx} = {s_rs, s_rt, s_rd, s_rddx};
  assign {ib.isSw_d, ib.isMD_d, ib.isLw_dx, ib.isMul_dx, ib.isDiv_dx, ib.MD_resultRDY_x} = {s_sw, s_md, s_lw, s_mul, s_div, s_rdy};

  hazard_scoreboard #(.REG_W(5), .MD_SLOTS(2), .LOAD_LAT(1), .SW_BYPASS(1'b1), .CNT_W(32)) dut_a (
    .clock(clock), .reset(rst_n), .bus(ia)
  );
  hazard_scoreboard #(.REG_W(5), .MD_SLOTS(2), .LOAD_LAT(2), .SW_BYPASS(1'b0), .CNT_W(4)) dut_b (
    .clock(clock), .reset(rst_n), .bus(ib)
  );

  function automatic bit m(input logic [4:0] x, y);
    return x == y && x != 5'd0;
  endfunction

  // returns {full, dep, load} as the rules dictate for the given load latency and store bypass
  function automatic logic [2:0] causes(input int lat, input bit swb);
    logic [4:0] d;
    bit ld = 0, dep = 0, push;
    int nxt;
    push = s_mul || s_div;
    for (int k = 0; k < lat; k++) begin
      if (k == 0) d = s_lw ? s_rddx : 5'd0;
      else d = prev[k-1];
      if (m(d, s_rs) || m(d, s_rt) || (s_sw && !swb && m(d, s_rd))) ld = 1;
    end
    foreach (mdq[i]) if (m(mdq[i], s_rs) || m(mdq[i], s_rt) || m(mdq[i], s_rd)) dep = 1;
    if (push && (m(s_rddx, s_rs) || m(s_rddx, s_rt) || m(s_rddx, s_rd))) dep = 1;
    nxt = mdq.size() - ((s_rdy && mdq.size() > 0) ? 1 : 0) + (push ? 1 : 0);
    return {s_md && nxt == 2, dep, ld};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    logic [2:0] la, lb;
    if (!rst_n) begin
      mdq.delete();
      prev = '{default: '0};
      ca_s = 0; ca_m = 0; cb_s = 0; cb_m = 0;
    end else begin
      la = causes(1, 1'b1);
      lb = causes(2, 1'b0);
      if (|la && ca_s < MAX_A) ca_s++;
      if ((la[1] || la[2]) && ca_m < MAX_A) ca_m++;
      if (|lb && cb_s < MAX_B) cb_s++;
      if ((lb[1] || lb[2]) && cb_m < MAX_B) cb_m++;
      if (s_rdy && mdq.size() > 0) void'(mdq.pop_front());
      if (s_mul || s_div) mdq.push_back(s_rddx);
      prev[1] = prev[0];
      prev[0] = s_lw ? s_rddx : 5'd0;
    end
  end

  always @(negedge clock) begin
    logic [2:0] ea, eb;
    ea = causes(1, 1'b1);
    eb = causes(2, 1'b0);
    chk("a.stall", ia.stall, |ea);
    chk("a.load_stall", ia.load_stall, ea[0]);
    chk("a.md_dep_stall", ia.md_dep_stall, ea[1]);
    chk("a.md_full_stall", ia.md_full_stall, ea[2]);
    chk("a.md_pending", ia.md_pending, mdq.size());
    chk("a.stall_cnt", ia.stall_cnt, ca_s);
    chk("a.md_stall_cnt", ia.md_stall_cnt, ca_m);
    chk("b.stall", ib.stall, |eb);
    chk("b.load_stall", ib.load_stall, eb[0]);
    chk("b.md_dep_stall", ib.md_dep_stall, eb[1]);
    chk("b.md_full_stall", ib.md_full_stall, eb[2]);
    chk("b.md_pending", ib.md_pending, mdq.size());
    chk("b.stall_cnt", ib.stall_cnt, cb_s);
    chk("b.md_stall_cnt", ib.md_stall_cnt, cb_m);
  end

  task automatic cyc(input logic [4:0] rs, rt, rd, input logic sw, md, input logic [4:0] rddx,
                     input logic lw, mul, div, rdy);
    @(posedge clock);
    #1;
    {s_rs, s_rt, s_rd, s_sw, s_md, s_rddx, s_lw, s_mul, s_div, s_rdy} = {rs, rt, rd, sw, md, rddx, lw, mul, div, rdy};
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("reset stall", ia.stall, 0);
    chk("reset pending", ia.md_pending, 0);
    chk("reset stall_cnt", ia.stall_cnt, 0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    idle();
    // load-use: lw r5 in DX, D = add r6,r5,r1
    cyc(5, 1, 6, 0, 0, 5, 1, 0, 0, 0);
    chk("lu a.stall", ia.stall, 1);
    chk("lu a.load_stall", ia.load_stall, 1);
    chk("lu b.stall", ib.stall, 1);
    cyc(5, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("lu a.release", ia.stall, 0);
    chk("lu b.second", ib.stall, 1);
    cyc(5, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("lu b.release", ib.stall, 0);
    chk("lu a.stall_cnt", ia.stall_cnt, 1);
    chk("lu b.stall_cnt", ib.stall_cnt, 2);
    // store data from a load: bypassed on a, stalls on b
    cyc(2, 0, 5, 1, 0, 5, 1, 0, 0, 0);
    chk("sw a.stall", ia.stall, 0);
    chk("sw b.stall", ib.stall, 1);
    idle();
    // mul r7 issues, independent add, then dependent add
    cyc(2, 3, 8, 0, 0, 7, 0, 1, 0, 0);
    chk("mul indep", ia.stall, 0);
    cyc(7, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("mul pending", ia.md_pending, 1);
    chk("mul dep", ia.md_dep_stall, 1);
    cyc(7, 1, 9, 0, 0, 0, 0, 0, 0, 1);
    chk("mul dep on pop", ia.stall, 1);
    cyc(7, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("mul released", ia.stall, 0);
    chk("mul drained", ia.md_pending, 0);
    // fill both slots, then a div in D
    cyc(0, 0, 0, 0, 0, 10, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 11, 0, 1, 0, 0);
    chk("fill pending1", ia.md_pending, 1);
    cyc(1, 2, 12, 0, 1, 0, 0, 0, 0, 0);
    chk("full pending2", ia.md_pending, 2);
    chk("full stall", ia.md_full_stall, 1);
    cyc(1, 2, 12, 0, 1, 0, 0, 0, 0, 1);
    chk("full freed by pop", ia.md_full_stall, 0);
    cyc(0, 0, 0, 0, 0, 12, 0, 0, 1, 0);
    chk("div pending1", ia.md_pending, 1);
    cyc(0, 0, 0, 0, 0, 13, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("push+pop pending2", ia.md_pending, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain pending1", ia.md_pending, 1);
    idle();
    chk("drain pending0", ia.md_pending, 0);
    // r0 never a hazard
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("r0 a.stall", ia.stall, 0);
    chk("r0 b.stall", ib.stall, 0);
    // reset in the middle of a multdiv dependence
    cyc(0, 0, 0, 0, 0, 14, 0, 1, 0, 0);
    cyc(14, 0, 15, 0, 0, 0, 0, 0, 0, 0);
    chk("pre-reset stall", ia.stall, 1);
    chk("pre-reset pending", ia.md_pending, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    {s_rs, s_rt, s_rd, s_sw, s_md, s_rddx, s_lw, s_mul, s_div, s_rdy} = '0;
    #1;
    chk("rst pending", ia.md_pending, 0);
    chk("rst a.stall_cnt", ia.stall_cnt, 0);
    chk("rst a.md_stall_cnt", ia.md_stall_cnt, 0);
    chk("rst b.stall_cnt", ib.stall_cnt, 0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    // hold a load-use stall for 2^4+3 cycles
    repeat (19) cyc(5, 0, 6, 0, 0, 5, 1, 0, 0, 0);
    idle();
    chk("sat a.stall_cnt", ia.stall_cnt, 19);
    chk("sat b.stall_cnt", ib.stall_cnt, 15);
    idle();
    chk("sat b.hold", ib.stall_cnt, 15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised stall/hazard unit for the 5-stage pipeline. It replaces coarse multdiv stalling with a destination scoreboard, so the pipe stalls only when an instruction in D actually depends on an outstanding multdiv result. It also supports a configurable load-use latency. It sits beside the D/X latches, drives the global stall (freeze PC and F/D, bubble D/X) and exposes per-cause stall counters.

Parameters:
REG_W, 5, register-address width; register 0 is hardwired zero and never a hazard
MD_SLOTS, 2, max outstanding multdiv ops (in-order FIFO depth, power of 2, >=1)
LOAD_LAT, 1, load-use bubbles required; checked stages = LOAD_LAT (1 = DX only)
SW_BYPASS, 1, 1: store-data (rd of sw) dependence on a load does not stall (forwarded at M)
CNT_W, 32, width of stall counters

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
rs_d  in  REG_W  D-stage source A
rt_d  in  REG_W  D-stage source B
rd_d  in  REG_W  D-stage destination (store data register for sw)
isSw_d  in  1  D is a store
isMD_d  in  1  D is mul or div
rd_dx  in  REG_W  DX destination
isLw_dx  in  1  DX is a load
isMul_dx  in  1  DX is mul (issues to multdiv this cycle)
isDiv_dx  in  1  DX is div (issues this cycle)
MD_resultRDY_x  in  1  multdiv retires oldest op this cycle
stall  out  1  freeze F/D, bubble D/X
load_stall  out  1  cause: load-use
md_dep_stall  out  1  cause: RAW/WAW on pending multdiv dest
md_full_stall  out  1  cause: multdiv FIFO full and D is mul/div
md_pending  out  MD_SLOTS+1  outstanding multdiv count
stall_cnt  out  CNT_W  cycles with stall=1
md_stall_cnt  out  CNT_W  cycles with md_dep_stall|md_full_stall

Behaviour:
- Reset (reset=0, async): FIFO empty, md_pending=0, load shift chain cleared to 0, counters 0; stall and all causes 0 on the next evaluation.
- Hazard match(a,b): a==b && a!=0.
- Load chain: LOAD_LAT-1 registered stages ld[1..]. Each edge shifts in (isLw_dx ? rd_dx : 0); ld[0] is the live rd_dx when isLw_dx, else 0. load_stall = any stage k matches rs_d or rt_d, or matches rd_d when isSw_d && !SW_BYPASS. With LOAD_LAT=1 it is purely combinational.
- MD FIFO: push rd_dx when (isMul_dx|isDiv_dx); pop when MD_resultRDY_x. Push and pop in the same cycle: count unchanged, both applied. Pop on empty is ignored and flags the sim assertion. Push on full cannot occur, because md_full_stall blocks it; an assertion checks this.
- md_dep_stall: any valid FIFO entry, or the issuing rd_dx this cycle, matches rs_d, rt_d, or rd_d (WAW; rd_d is always checked). An entry popping this cycle still counts: its result reaches writeback next cycle, and forwarding covers it after that.
- md_full_stall: isMD_d && (count - pop + push) == MD_SLOTS.
- stall = load_stall | md_dep_stall | md_full_stall. Combinational from inputs and current state, with zero added latency.
- Counters: increment on the edge when the condition is 1; saturate at all-ones with no wrap.
- Reset mid-operation discards FIFO contents; the multdiv unit is reset by the same signal.

Decomposition:
- Shared package holds REG_W, the zero-register constant, and the stall-cause bit indices for the debug bus.
- One sub-module, hazard_dest_fifo: depth MD_SLOTS, push/pop/count, parallel compare of all valid entries against three addresses, returning a hit bit.

Test Plan:
- lw r5 in DX, D = add r6,r5,r1 -> stall=1, load_stall=1, one cycle. With LOAD_LAT=2: stall for 2 consecutive cycles.
- lw r5 in DX, D = sw r5 with SW_BYPASS=1 -> stall=0. Same with SW_BYPASS=0 -> stall=1.
- mul r7 issues, D = add r8,r2,r3 (independent) -> stall=0, md_pending=1. Then D = add r9,r7,r1 -> stall held until MD_resultRDY_x pulses, released next cycle.
- MD_SLOTS=2: two muls outstanding, D=div -> md_full_stall=1. Pop and push together -> md_pending stays 2.
- Dependence on r0 (lw r0 in DX, D reads r0) -> stall=0. Assert reset mid-multdiv -> md_pending=0 and counters=0 immediately.
- Hold stall for 2^CNT_W+3 cycles with CNT_W=4 -> stall_cnt saturates at 15.
